alu_sequencer: RTL

//  Multi-cycle control sequencer for the regfile + operand mux + ALU datapath. Accepts one
//  RV32I instruction per valid/ready handshake and decodes it. Drives the register addresses,

---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control sequencer for an RV32I regfile/ALU datapath.
// Each instruction takes four cycles: IDLE -> DECODE -> EXEC -> WB.
// Supported ops are addi, add and bne. Every other encoding raises a one-cycle illegal pulse.
// Optional feature: define SEQ_PERF_CNT_EN to add the retired_cnt and taken_cnt counters.
module alu_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_ready,
  input  logic                  EQ,
  output logic [ADDR_WIDTH-1:0] AD1,
  output logic [ADDR_WIDTH-1:0] AD2,
  output logic [ADDR_WIDTH-1:0] AD3,
  output logic                  WE3,
  output logic                  ALUsrc,
  output logic                  ALUctrl,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  busy,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]           retired_cnt,
  output logic [31:0]           taken_cnt,
`endif
  output logic                  illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] ir;
  logic                  op_write;
  logic                  op_bne;
  logic                  op_ill;

  logic [ADDR_WIDTH-1:0] dec_ad1, dec_ad2, dec_ad3;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_src, dec_ctrl, dec_write, dec_bne, dec_ill;
  logic [DATA_WIDTH-1:0] pc_branch;

  logic handshake;
  assign handshake   = instr_valid && instr_ready;
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // The branch target is forced to an even address.
  assign pc_branch = pc + ImmOp;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: fixed walk through the four states once an instruction is accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the accepted instruction word; it stays put until the next handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ir <= '0;
    else if (handshake) ir <= instr;
  end

  // Combinational decode of the latched word. Unsupported encodings leave all fields at zero.
  always_comb begin
    dec_ad1   = '0;
    dec_ad2   = '0;
    dec_ad3   = '0;
    dec_imm   = '0;
    dec_src   = 1'b0;
    dec_ctrl  = 1'b0;
    dec_write = 1'b0;
    dec_bne   = 1'b0;
    dec_ill   = 1'b0;
    if (ir[6:0] == 7'b0010011 && ir[14:12] == 3'b000) begin
      dec_ad1   = ir[19:15];
      dec_ad3   = ir[11:7];
      dec_imm   = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
      dec_src   = 1'b1;
      dec_write = (ir[11:7] != 5'd0);
    end else if (ir[6:0] == 7'b0110011 && ir[14:12] == 3'b000 && ir[31:25] == 7'b0000000) begin
      dec_ad1   = ir[19:15];
      dec_ad2   = ir[24:20];
      dec_ad3   = ir[11:7];
      dec_write = (ir[11:7] != 5'd0);
    end else if (ir[6:0] == 7'b1100011 && ir[14:12] == 3'b001) begin
      dec_ad1   = ir[19:15];
      dec_ad2   = ir[24:20];
      dec_imm   = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      dec_ctrl  = 1'b1;
      dec_bne   = 1'b1;
    end else begin
      dec_ill   = 1'b1;
    end
  end

  // Datapath controls are registered at the end of DECODE and hold until the next DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AD1      <= '0;
      AD2      <= '0;
      AD3      <= '0;
      ImmOp    <= '0;
      ALUsrc   <= 1'b0;
      ALUctrl  <= 1'b0;
      op_write <= 1'b0;
      op_bne   <= 1'b0;
      op_ill   <= 1'b0;
    end else if (state == DECODE) begin
      AD1      <= dec_ad1;
      AD2      <= dec_ad2;
      AD3      <= dec_ad3;
      ImmOp    <= dec_imm;
      ALUsrc   <= dec_src;
      ALUctrl  <= dec_ctrl;
      op_write <= dec_write;
      op_bne   <= dec_bne;
      op_ill   <= dec_ill;
    end
  end

  // WE3 and illegal are one-cycle pulses that are high exactly while the FSM sits in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      WE3     <= (state == EXEC) && op_write;
      illegal <= (state == EXEC) && op_ill;
    end
  end

  // The PC commits at the end of WB. EQ is only looked at here and only matters for bne.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (state == WB) begin
      if (op_bne && !EQ) pc <= {pc_branch[DATA_WIDTH-1:1], 1'b0};
      else               pc <= pc + DATA_WIDTH'(4);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Retired legal ops and taken branches; both counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else if (state == WB) begin
      if (!op_ill)        retired_cnt <= retired_cnt + 32'd1;
      if (op_bne && !EQ)  taken_cnt   <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule
